// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmit engine.
// Handles launch, completion/timeout wait, inter-character gap and grant lock.
module uart_tx_sched #(
    parameter int NREQ  = 4,
    parameter int GAP_W = 8,
    parameter int TMO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*8-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   gnt,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [GAP_W-1:0]  gap_cfg,
    input  logic [TMO_W-1:0]  tmo_cfg,
    output logic              timeout_err,
    output logic [7:0]        err_cnt,
    output logic [15:0]       char_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [TMO_W-1:0] tmr_q, tmr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       err_q, err_d;
    logic [15:0]      chr_q, chr_d;

    logic [IW-1:0]    win;
    logic [IW-1:0]    idx;
    logic             tmo_hit;
    logic             gap_end;
    logic             relaunch;

    // Walk offsets downward so the offset right after last_q is assigned last and wins.
    always_comb begin
        win = last_q;
        idx = last_q;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(last_q) + i) % NREQ);
            if (req[idx]) win = idx;
        end
    end

    assign tmo_hit  = (tmo_cfg != '0) && (tmr_q == tmo_cfg - 1'b1);
    assign gap_end  = (gap_cfg == '0) || (gap_q >= gap_cfg - 1'b1);
    assign relaunch = lock[owner_q] & req[owner_q] & enable & ~tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            tmr_q   <= '0;
            gap_q   <= '0;
            err_q   <= '0;
            chr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            chr_q   <= chr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;
        err_d   = err_q;
        chr_d   = chr_q;
        unique case (state_q)
            IDLE: begin
                if (enable && !tx_busy && (|req)) begin
                    owner_d = win;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                last_d  = owner_q;
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    chr_d   = chr_q + 16'd1;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (tmo_hit) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_d = relaunch ? LAUNCH : IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt         = '0;
        ack         = '0;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        timeout_err = 1'b0;
        if (state_q != IDLE) gnt[owner_q] = 1'b1;
        if (state_q == LAUNCH) begin
            tx_start     = 1'b1;
            ack[owner_q] = 1'b1;
            tx_data      = data[{owner_q, 3'b000} +: 8];
        end
        if ((state_q == WAIT) && !tx_done && tmo_hit) timeout_err = 1'b1;
    end

    assign err_cnt  = err_q;
    assign char_cnt = chr_q;

endmodule
